// File: rtl/parity_pkg.sv
// ---------------------------------------------------------------------------
// parity_pkg
// Definitions shared by the even-parity transmit and receive blocks:
//   rx_state_t : receive-side frame sequencer states
//   START_BIT  : line level that marks the start of a frame
//   STOP_BIT   : line level expected in the stop-bit slot
// ---------------------------------------------------------------------------
package parity_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage : parity_pkg

// File: rtl/parity_frame_checker.sv
// ---------------------------------------------------------------------------
// parity_frame_checker
// Deserialises a frame (start, DATA_W data bits LSB first, even parity bit,
// stop bit) received one bit per rx_valid strobe, checks parity and stop bit,
// and presents the word with its error flags. A saturating counter records
// the number of frames that carried any error.
//
// Ports:
//   clk        : rising-edge clock
//   rst        : asynchronous, active-high reset
//   rx_bit     : serial line value, sampled only while rx_valid=1
//   rx_valid   : bit strobe, one received bit per cycle it is high
//   clr_cnt    : synchronous clear of err_count (wins over an increment)
//   data_out   : last received data word
//   data_valid : one-cycle pulse after a frame completes
//   parity_err : parity flag of the last completed frame
//   frame_err  : stop-bit flag of the last completed frame
//   err_count  : saturating count of frames with any error
//   busy       : high whenever a frame is in progress
// ---------------------------------------------------------------------------
module parity_frame_checker
   import parity_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_bit,
   input  logic              rx_valid,
   input  logic              clr_cnt,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              parity_err,
   output logic              frame_err,
   output logic [CNT_W-1:0]  err_count,
   output logic              busy
);

   localparam int             BCW      = $clog2(DATA_W);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

   rx_state_t         state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
   logic              acc_q, acc_d;
   logic              perr_q, perr_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              data_valid_q, data_valid_d;
   logic              parity_err_q, parity_err_d;
   logic              frame_err_q, frame_err_d;
   logic [CNT_W-1:0]  err_count_q, err_count_d;
   logic              frame_bad;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      state_d      = state_q;
      shift_d      = shift_q;
      bit_cnt_d    = bit_cnt_q;
      acc_d        = acc_q;
      perr_d       = perr_q;
      data_out_d   = data_out_q;
      parity_err_d = parity_err_q;
      frame_err_d  = frame_err_q;
      data_valid_d = 1'b0;
      frame_bad    = 1'b0;

      if (rx_valid) begin
         unique case (state_q)
            IDLE: begin
               if (rx_bit == START_BIT) begin
                  state_d   = DATA;
                  shift_d   = '0;
                  bit_cnt_d = '0;
                  acc_d     = 1'b0;
               end
            end
            DATA: begin
               // Shift in from the top: after DATA_W bits the first bit
               // received has reached bit 0.
               shift_d = {rx_bit, shift_q[DATA_W-1:1]};
               acc_d   = acc_q ^ rx_bit;
               if (bit_cnt_q == LAST_BIT) begin
                  state_d = PARITY;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
            PARITY: begin
               perr_d  = acc_q ^ rx_bit;
               state_d = STOP;
            end
            STOP: begin
               data_out_d   = shift_q;
               parity_err_d = perr_q;
               frame_err_d  = (rx_bit != STOP_BIT);
               data_valid_d = 1'b1;
               frame_bad    = perr_q | (rx_bit != STOP_BIT);
               state_d      = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end

      // Clear takes priority over a coincident increment.
      err_count_d = err_count_q;
      if (clr_cnt) begin
         err_count_d = '0;
      end else if (frame_bad && (err_count_q != {CNT_W{1'b1}})) begin
         err_count_d = err_count_q + 1'b1;
      end
   end

   // NOTE: state is updated only with non-blocking assignments so every flop
   // samples the values from before the edge, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         acc_q        <= 1'b0;
         perr_q       <= 1'b0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         err_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         bit_cnt_q    <= bit_cnt_d;
         acc_q        <= acc_d;
         perr_q       <= perr_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
         err_count_q  <= err_count_d;
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;
   assign err_count  = err_count_q;
   assign busy       = (state_q != IDLE);

endmodule : parity_frame_checker

// File: tb/tb_parity_frame_checker.sv
// ---------------------------------------------------------------------------
// tb_parity_frame_checker
// Two instances share the serial inputs: dut (CNT_W=8) and dut_sat (CNT_W=2,
// for counter saturation). Expected frame results are queued when the stop
// bit is driven; a monitor queues observed results on each data_valid pulse.
// ---------------------------------------------------------------------------
module tb_parity_frame_checker;

   typedef struct {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
      logic [7:0] cnt;
      logic [1:0] cnt2;
   } res_t;

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       stop;
      logic       exp_perr;
      logic       exp_ferr;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_bit = 1'b1;
   logic       rx_valid = 1'b0;
   logic       clr_cnt = 1'b0;

   logic [7:0] data_out, data_out2;
   logic       data_valid, data_valid2;
   logic       parity_err, parity_err2;
   logic       frame_err, frame_err2;
   logic [7:0] err_count;
   logic [1:0] err_count2;
   logic       busy, busy2;

   int checks = 0;
   int errors = 0;
   int m_cnt  = 0;
   int m_cnt2 = 0;

   res_t exp_q[$];
   res_t obs_q[$];

   always #5 clk = ~clk;

   parity_frame_checker #(.DATA_W(8), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .rx_bit(rx_bit), .rx_valid(rx_valid), .clr_cnt(clr_cnt),
      .data_out(data_out), .data_valid(data_valid), .parity_err(parity_err),
      .frame_err(frame_err), .err_count(err_count), .busy(busy)
   );

   parity_frame_checker #(.DATA_W(8), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .rx_bit(rx_bit), .rx_valid(rx_valid), .clr_cnt(clr_cnt),
      .data_out(data_out2), .data_valid(data_valid2), .parity_err(parity_err2),
      .frame_err(frame_err2), .err_count(err_count2), .busy(busy2)
   );

   always @(negedge clk) begin
      if (data_valid) begin
         obs_q.push_back('{data_out, parity_err, frame_err, err_count, err_count2});
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic strobe(input logic b, input logic clr);
      rx_bit   = b;
      rx_valid = 1'b1;
      clr_cnt  = clr;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      clr_cnt  = 1'b0;
      rx_bit   = 1'b1;
   endtask

   task automatic gap(input int max_gap);
      if (max_gap > 0) idle($urandom_range(max_gap, 0));
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                             input int max_gap, input logic clr_at_stop,
                             input logic eperr, input logic eferr);
      res_t r;
      strobe(1'b0, 1'b0);
      check("busy_after_start", busy, 1'b1);
      for (int i = 0; i < 8; i++) begin
         gap(max_gap);
         strobe(d[i], 1'b0);
      end
      gap(max_gap);
      strobe(p, 1'b0);
      gap(max_gap);
      check("busy_before_stop", busy, 1'b1);
      if (clr_at_stop) begin
         m_cnt  = 0;
         m_cnt2 = 0;
      end else if (eperr || eferr) begin
         if (m_cnt < 255) m_cnt++;
         if (m_cnt2 < 3) m_cnt2++;
      end
      r.data = d;
      r.perr = eperr;
      r.ferr = eferr;
      r.cnt  = 8'(m_cnt);
      r.cnt2 = 2'(m_cnt2);
      exp_q.push_back(r);
      strobe(s, clr_at_stop);
      check("busy_after_stop", busy, 1'b0);
   endtask

   // Compare every queued expectation with an observed result, then confirm
   // that no extra data_valid pulse follows.
   task automatic drain();
      res_t e, o;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         for (int t = 0; t < 10 && obs_q.size() == 0; t++) idle(1);
         if (obs_q.size() == 0) begin
            check("frame_output_timeout", 1'b0, 1'b1);
         end else begin
            o = obs_q.pop_front();
            check("data_out", o.data, e.data);
            check("parity_err", o.perr, e.perr);
            check("frame_err", o.ferr, e.ferr);
            check("err_count", o.cnt, e.cnt);
            check("err_count_sat", o.cnt2, e.cnt2);
         end
      end
      idle(2);
      check("extra_valid_pulses", obs_q.size(), 0);
      obs_q.delete();
   endtask

   vec_t vecs[7];

   initial begin
      vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{8'h07, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[6] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b1};

      // Reset state while rst is held.
      #2;
      check("rst_data_out", data_out, 8'h00);
      check("rst_data_valid", data_valid, 1'b0);
      check("rst_parity_err", parity_err, 1'b0);
      check("rst_frame_err", frame_err, 1'b0);
      check("rst_err_count", err_count, 8'h00);
      check("rst_busy", busy, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);

      // Table-driven frames, one strobe per cycle.
      foreach (vecs[i]) begin
         send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, 0, 1'b0,
                    vecs[i].exp_perr, vecs[i].exp_ferr);
         drain();
      end

      // Back-to-back frames: next start bit on the strobe after the stop bit.
      send_frame(8'hC3, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
      send_frame(8'h81, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0);
      drain();

      // Idle-line strobes, then a frame with random stalls between bits.
      strobe(1'b1, 1'b0);
      strobe(1'b1, 1'b0);
      check("busy_idle_line", busy, 1'b0);
      send_frame(8'hA5, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0);
      drain();

      // Asynchronous reset mid-frame, between clock edges.
      strobe(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) strobe(1'b1, 1'b0);
      #3;
      rst = 1'b1;
      #1;
      check("midrst_data_out", data_out, 8'h00);
      check("midrst_parity_err", parity_err, 1'b0);
      check("midrst_frame_err", frame_err, 1'b0);
      check("midrst_err_count", err_count, 8'h00);
      check("midrst_data_valid", data_valid, 1'b0);
      check("midrst_busy", busy, 1'b0);
      @(posedge clk);
      #1;
      rst    = 1'b0;
      m_cnt  = 0;
      m_cnt2 = 0;
      idle(2);
      check("midrst_no_output", obs_q.size(), 0);
      send_frame(8'h5A, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
      drain();

      // Saturation on the 2-bit counter, then clear coinciding with an error.
      clr_cnt = 1'b1;
      idle(1);
      clr_cnt = 1'b0;
      m_cnt   = 0;
      m_cnt2  = 0;
      check("clr_idle_count", err_count, 8'h00);
      for (int i = 0; i < 5; i++) begin
         send_frame(8'h01, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0);
         drain();
      end
      check("sat_count", err_count2, 2'd3);
      check("nonsat_count", err_count, 8'd5);
      send_frame(8'h01, 1'b0, 1'b1, 0, 1'b1, 1'b1, 1'b0);
      drain();
      check("clr_wins_sat", err_count2, 2'd0);
      check("clr_wins", err_count, 8'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_parity_frame_checker

// File: doc/parity_frame_checker.md
Name: parity_frame_checker

Overview:
Receive-side counterpart of the team's even-parity generator. It accepts a serial frame one bit per strobe: start bit, DATA_W data bits (LSB first), the even-parity bit, then the stop bit. It deserialises the data, checks parity and framing, and presents the word with error flags. A saturating error counter is kept for lab observation.

Parameters:
DATA_W, 8, number of data bits per frame (legal range 2..32)
CNT_W, 8, width of the saturating error counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
rx_bit  input  1  serial line value; sampled only when rx_valid=1
rx_valid  input  1  bit strobe; one received bit per cycle where it is high
clr_cnt  input  1  synchronous clear of err_count
data_out  output  DATA_W  last received data word
data_valid  output  1  one-cycle pulse when a frame completes
parity_err  output  1  parity flag of the last completed frame
frame_err  output  1  stop-bit flag of the last completed frame
err_count  output  CNT_W  saturating count of frames with any error
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset: rst=1 forces the following immediately, regardless of clock:
  - state=IDLE
  - data_out=0, data_valid=0, parity_err=0, frame_err=0
  - err_count=0, busy=0
  - internal shift register, bit counter and parity accumulator cleared
- Reset mid-frame abandons the partial frame with no outputs produced.
- All state advances only on edges where rx_valid=1. Cycles with rx_valid=0 change nothing except the data_valid drop and clr_cnt.
- IDLE:
  - rx_bit=0 → DATA; clear the shift register, bit_cnt=0, acc=0.
  - rx_bit=1 (idle line) → stay in IDLE.
- DATA:
  - Shift the bit in LSB-first: bit k of the word is the k-th data bit received.
  - acc ^= rx_bit.
  - When bit_cnt==DATA_W-1 → PARITY; otherwise bit_cnt+1.
- PARITY: register perr = acc ^ rx_bit (nonzero means an odd count of ones) → STOP.
- STOP: on the rx_valid edge, load data_out, parity_err and frame_err (frame_err = ~rx_bit), set data_valid=1 → IDLE.
  - Data and flags are always delivered, even when an error is flagged.
- Latency: outputs are visible in the cycle after the edge that samples the stop bit.
  - data_valid is high for exactly one cycle.
  - data_out and flags hold until the next completed frame.
- A frame starting directly after a stop bit (IDLE sampling 0 on the next strobe) is legal, with no gap required.
- err_count:
  - Increments on the stop-bit edge when (perr | frame_err).
  - Saturates at 2^CNT_W-1; no wrap-around.
  - clr_cnt=1 sets it to 0. If clr_cnt and an increment land on the same edge, clear wins and the result is 0.
- Parity convention matches the generator: the parity bit is the XOR of the data bits, so data plus parity must have an even number of ones.
- No timeout: a stalled rx_valid holds the frame in progress indefinitely.

Decomposition:
- Shared package parity_pkg holds:
  - typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t
  - localparam START_BIT=1'b0 and STOP_BIT=1'b1, shared with the transmit side
- No sub-module. The bit counter uses width $clog2(DATA_W) inside the module.

Test Plan:
1. DATA_W=8, frame 0, A5h LSB-first, parity 0, stop 1, one strobe per cycle → data_out=8'hA5, data_valid pulses one cycle, parity_err=0, frame_err=0, err_count=0.
2. Frame with data 07h (three ones), parity 0, stop 1 → data_out=8'h07, parity_err=1, frame_err=0, err_count=1. Repeat with parity 1 → parity_err=0, err_count stays 1.
3. Data 3Ch, parity 0, stop bit 0 → frame_err=1, parity_err=0, data_out=8'h3C, err_count increments by 1.
4. Frame A5h with rx_valid deasserted 0–3 random cycles between bits, plus idle 1-strobes before the start bit → results identical to scenario 1; busy high from the start bit until the stop bit.
5. rst pulsed after 4 data bits, mid-clock → all outputs 0 immediately, busy=0. The next full frame 5Ah decodes to data_out=8'h5A with no errors.
6. CNT_W=2, five bad-parity frames → err_count=3 (saturated). Then a bad frame whose stop edge coincides with clr_cnt=1 → err_count=0.
